// File: rtl/addsub_result_display.sv
// Captures the add/sub result on Load, converts it to signed decimal and drives a
// time-multiplexed 4-digit common-anode display (sign, blank, tens, ones), pins registered.
module addsub_result_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Load,
  input  logic [3:0] Sum,
  input  logic       Cout,
  input  logic       Sign,
  input  logic       Sub,
  output logic [3:0] An,
  output logic [6:0] Seg,
  output logic [5:0] Value
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [3:0]       sum_q;
  logic             cout_q, sign_q, sub_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic [5:0] value_w, abs_w;
  logic [4:0] mag_w, ones_w;
  logic [1:0] tens_w;
  logic       neg_w, bad_w, wrap_w;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  // Sum-16 for a borrow is just Sum with the upper two bits set.
  always_comb begin
    value_w = 6'd0;
    if (!sub_q)       value_w = {1'b0, cout_q, sum_q};
    else if (!sign_q) value_w = {2'b00, sum_q};
    else              value_w = {2'b11, sum_q};
  end

  assign neg_w = sub_q & sign_q;
  assign bad_w = neg_w & (sum_q == 4'd0);
  assign abs_w = neg_w ? (~value_w + 6'd1) : value_w;
  assign mag_w = abs_w[4:0];

  always_comb begin
    tens_w = 2'd0;
    ones_w = mag_w;
    if (mag_w >= 5'd30) begin
      tens_w = 2'd3;
      ones_w = mag_w - 5'd30;
    end else if (mag_w >= 5'd20) begin
      tens_w = 2'd2;
      ones_w = mag_w - 5'd20;
    end else if (mag_w >= 5'd10) begin
      tens_w = 2'd1;
      ones_w = mag_w - 5'd10;
    end
  end

  assign wrap_w = (cnt_q == CNT_LAST);
  assign cnt_d  = wrap_w ? '0 : cnt_q + CNT_W'(1);
  assign idx_d  = wrap_w ? idx_q + 2'd1 : idx_q;

  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    case (idx_q)
      2'd0: begin
        an_d = 4'b1110;
        if (!bad_w) seg_d = glyph(ones_w[3:0]);
      end
      2'd1: begin
        an_d = 4'b1101;
        if (!bad_w && tens_w != 2'd0) seg_d = glyph({2'b00, tens_w});
      end
      2'd2: an_d = 4'b1011;
      default: begin
        an_d = 4'b0111;
        if (neg_w) seg_d = SEG_MINUS;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q  <= 4'd0;
      cout_q <= 1'b0;
      sign_q <= 1'b0;
      sub_q  <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      an_q   <= 4'b1111;
      seg_q  <= SEG_BLANK;
    end else begin
      if (Load) begin
        sum_q  <= Sum;
        cout_q <= Cout;
        sign_q <= Sign;
        sub_q  <= Sub;
      end
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign An    = an_q;
  assign Seg   = seg_q;
  assign Value = value_w;

endmodule

// File: tb/tb_addsub_result_display.sv
// Bench for addsub_result_display: vector table, corner sequences and random traffic
// checked against an integer-arithmetic display model.
module tb_addsub_result_display;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Load = 1'b0;
  logic [3:0] Sum = 4'd0;
  logic       Cout = 1'b0, Sign = 1'b0, Sub = 1'b0;
  logic [3:0] An;
  logic [6:0] Seg;
  logic [5:0] Value;

  addsub_result_display #(.REFRESH_DIV(DIV), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .Load(Load), .Sum(Sum), .Cout(Cout),
    .Sign(Sign), .Sub(Sub), .An(An), .Seg(Seg), .Value(Value)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;        // edges since reset release
  int cur_val = 0;  // value held by the model

  logic [6:0] GLY [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;

  typedef struct {
    logic [3:0] sum;
    logic       cout, sign, sub;
    int         val;
    logic [6:0] ones_seg;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  function automatic int model_val(input logic [3:0] s, input logic co, input logic sg, input logic sb);
    if (!sb) return int'(co) * 16 + int'(s);
    if (!sg) return int'(s);
    return int'(s) - 16;
  endfunction

  function automatic logic [10:0] disp(input int idx, input int v);
    int m;
    logic [6:0] s;
    logic [3:0] a;
    m = (v < 0) ? -v : v;
    s = BLANK;
    case (idx)
      0: begin a = 4'b1110; if (v != -16) s = GLY[m % 10]; end
      1: begin a = 4'b1101; if (v != -16 && m / 10 != 0) s = GLY[m / 10]; end
      2: a = 4'b1011;
      default: begin a = 4'b0111; if (v < 0) s = MINUS; end
    endcase
    return {a, s};
  endfunction

  // One clock: expected pins reflect digit index and held value from before the edge.
  task automatic step(input logic ld, input logic [3:0] s, input logic co, input logic sg,
                      input logic sb, output logic [3:0] ea);
    logic [10:0] e;
    Load = ld; Sum = s; Cout = co; Sign = sg; Sub = sb;
    e = disp((n / DIV) % 4, cur_val);
    if (ld) cur_val = model_val(s, co, sg, sb);
    @(posedge clk); #1;
    n++;
    ea = e[10:7];
    check("an", 32'(An), 32'(e[10:7]));
    check("seg", 32'(Seg), 32'(e[6:0]));
    check("value", 32'($signed(Value)), 32'(cur_val));
  endtask

  task automatic idle(input int cyc);
    logic [3:0] ea;
    for (int i = 0; i < cyc; i++) step(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ea);
  endtask

  task automatic do_reset(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      reset = 1'b1; Load = 1'b1;
      Sum = 4'($urandom); Cout = 1'($urandom); Sign = 1'($urandom); Sub = 1'($urandom);
      @(posedge clk); #1;
      check("rst_an", 32'(An), 32'h0000000F);
      check("rst_seg", 32'(Seg), 32'h0000007F);
      check("rst_value", 32'(Value), 32'h0);
    end
    reset = 1'b0; Load = 1'b0;
    n = 0; cur_val = 0;
  endtask

  vec_t tbl [8];
  logic [3:0] ea;
  int saved;

  initial begin
    tbl[0] = '{4'd0,  1'b1, 1'b0, 1'b0,  16, 7'b0000010};
    tbl[1] = '{4'd14, 1'b0, 1'b1, 1'b1,  -2, 7'b0100100};
    tbl[2] = '{4'd14, 1'b1, 1'b0, 1'b0,  30, 7'b1000000};
    tbl[3] = '{4'd0,  1'b0, 1'b0, 1'b1,   0, 7'b1000000};
    tbl[4] = '{4'd9,  1'b0, 1'b1, 1'b1,  -7, 7'b1111000};
    tbl[5] = '{4'd0,  1'b0, 1'b1, 1'b1, -16, 7'b1111111};
    tbl[6] = '{4'd5,  1'b0, 1'b1, 1'b0,   5, 7'b0010010};
    tbl[7] = '{4'd3,  1'b1, 1'b0, 1'b1,   3, 7'b0110000};

    do_reset(3);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, ea);
    check("first_an", 32'(An), 32'h0000000E);
    check("first_seg", 32'(Seg), 32'h00000040);
    idle(4 * DIV + 2);

    foreach (tbl[k]) begin
      step(1'b1, tbl[k].sum, tbl[k].cout, tbl[k].sign, tbl[k].sub, ea);
      check("tbl_value", 32'($signed(Value)), 32'(tbl[k].val));
      for (int i = 0; i < 4 * DIV + 1; i++) begin
        step(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ea);
        if (ea == 4'b1110) check("tbl_ones", 32'(Seg), 32'(tbl[k].ones_seg));
      end
    end

    // Held value survives 50 cycles of toggling inputs.
    saved = cur_val;
    idle(50);
    check("hold_value", 32'($signed(Value)), 32'(saved));

    // Load on the wrap edge: following output uses new index and new value.
    while ((n % DIV) != DIV - 1) idle(1);
    step(1'b1, 4'd14, 1'b0, 1'b1, 1'b1, ea);
    check("wrap_value", 32'($signed(Value)), 32'(-2));
    idle(2 * DIV);

    // Reset while displaying idx2 with Value=-7.
    step(1'b1, 4'd9, 1'b0, 1'b1, 1'b1, ea);
    while (((n / DIV) % 4) != 2) idle(1);
    idle(1);
    check("pre_rst_an", 32'(An), 32'h0000000B);
    check("pre_rst_value", 32'($signed(Value)), 32'(-7));
    do_reset(2);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, ea);
    check("restart_an", 32'(An), 32'h0000000E);
    check("restart_seg", 32'(Seg), 32'h00000040);
    idle(DIV);

    // Random traffic with sporadic loads.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) == 0), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ea);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/addsub_result_display.md
Name: addsub_result_display

Overview:
- Downstream stage of the 4-bit adder/subtractor.
- Captures the arithmetic result (Sum, Cout, Sign, Sub) on a load strobe and converts it to a signed decimal value.
- Drives a time-multiplexed 4-digit common-anode seven-segment display: sign digit, blank, tens, ones.
- Sits between the add/sub datapath and board display pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit. Legal range is 2 or more.
- CNT_W, 17, width of the refresh counter. Must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Load  input  1  capture strobe; samples Sum/Cout/Sign/Sub on the clock edge where Load=1.
- Sum  input  4  unsigned result from the adder/subtractor.
- Cout  input  1  carry out; meaningful only when Sub=0.
- Sign  input  1  borrow flag (negative result); meaningful only when Sub=1.
- Sub  input  1  mode of the captured operation: 0 = add, 1 = subtract.
- An  output  4  digit enables, active-low. An[0] = ones, An[1] = tens, An[2] = unused, An[3] = sign.
- Seg  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- Value  output  6  captured signed result, two's complement, range -15..+30 (debug/verification).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - hold registers = 0, so Value = 0
  - refresh counter = 0
  - digit index = 0
  - An = 4'b1111
  - Seg = 7'b1111111
- Capture:
  - Load=1 at an edge registers {Sum, Cout, Sign, Sub}.
  - Value updates at that same edge.
  - Load=0 means the hold registers are unchanged, whatever the inputs do.
  - Load has no handshake; a multi-cycle Load re-captures every cycle.
- Value decode from the hold registers:
  - Sub=0: Value = {Cout, Sum}, range 0..30. Sign is ignored.
  - Sub=1, Sign=0: Value = Sum, range 0..15.
  - Sub=1, Sign=1: Value = Sum - 16, range -15..-1. Cout is ignored.
  - The case Sub=1, Sign=1, Sum=0 cannot be produced upstream; if it occurs, decode it as -16 and display "-" with the sign digit only (tens and ones blank).
- Magnitude M = |Value|. Tens T = M/10 (0..3), ones O = M mod 10. Implement with compare/subtract only; no divider.
- Refresh:
  - The counter counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap cycle, digit index increments mod 4 (0→1→2→3→0).
- Output register:
  - An and Seg are registered from the current digit index and hold registers.
  - Latency is 1 cycle from an index change or capture to the pins.
  - Exactly one An bit is low per cycle after the first post-reset cycle, including for blank digits.
- Digit content:
  - idx0: An=1110, shows glyph O.
  - idx1: An=1101, shows glyph T, or blank if T=0 (leading-zero blanking).
  - idx2: An=1011, always blank.
  - idx3: An=0111, shows minus if Value<0, else blank.
- Glyphs:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - minus=0111111, blank=1111111
- Simultaneous events:
  - Capture on a wrap cycle: the next output shows the new digit index with the new value.
  - Reset wins over Load and over the refresh wrap.
- Reset mid-scan: all state returns to reset values at the next edge. Scanning resumes at idx0 after REFRESH_DIV cycles at idx0.

Test Plan:
- Reset held 3 cycles with REFRESH_DIV=4 -> An=1111, Seg=1111111, Value=0. The first cycle after release gives An=1110, Seg=1000000 ("0"). Digit index advances every 4 cycles.
- Add 9+7: Load with Sum=0, Cout=1, Sub=0 -> Value=16. Scan shows ones "6" (0000010), tens "1" (1111001), idx2 blank, idx3 blank.
- Sub 3-5: Load with Sum=14, Sign=1, Sub=1, Cout=0 -> Value=-2 (6'b111110). idx0 "2" (0100100), idx1 blank, idx3 minus (0111111).
- Add 15+15: Load with Sum=14, Cout=1, Sub=0 -> Value=30. idx1 "3" (0110000), idx0 "0". Then sub 5-5 (Sum=0, Sign=0, Sub=1) -> Value=0, only idx0 lit with "0"; tens and sign blank.
- Load=0 while Sum/Cout/Sign/Sub toggle randomly for 50 cycles -> Value and the displayed glyphs are unchanged. Load pulsed on a wrap cycle -> the next An/Seg reflect the new value at the new index.
- Assert reset while idx=2 with Value=-7, then release -> Value=0, An=1111 during reset, restart at idx0 showing "0".
